visor_av_writer: RTL and testbench

- Avalon-MM write master downstream of the visor MCU. It consumes the visor's register-load strobes and drives the visor's av_address/av_writedata/av_write/av_waitrequest bus.
- The visor sets a target address, then stores data words. Each word is queued with its address in a small FIFO and issued as one Avalon write.
- The visor is never stalled by av_waitrequest. It polls the status outputs instead.

---
 rtl/visor_av_pkg.sv | 13 +
 rtl/visor_av_writer_if.sv | 9 +
 rtl/visor_sync_fifo.sv | 41 ++++
 rtl/visor_av_writer.sv | 65 ++++++
 tb/tb_visor_av_writer.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/visor_av_pkg.sv
// visor_av_pkg: shared types and status bit positions for the visor Avalon writer
package visor_av_pkg;
    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } av_entry_t;
    typedef enum logic {AVW_IDLE, AVW_WRITE} av_state_t;
    localparam int ST_AUTO_INC = 0;
    localparam int ST_BUSY     = 1;
    localparam int ST_EMPTY    = 2;
    localparam int ST_FULL     = 3;
    localparam int ST_OVERFLOW = 4;
endpackage

// File: rtl/visor_av_writer_if.sv
// visor_av_writer_if: Avalon-MM write bus (address, writedata, write out of master; waitrequest into master)
interface visor_av_writer_if;
    logic [15:0] address;
    logic [15:0] writedata;
    logic        write;
    logic        waitrequest;
    modport master(output address, writedata, write, input waitrequest);
    modport slave(input address, writedata, write, output waitrequest);
endinterface

// File: rtl/visor_sync_fifo.sv
// visor_sync_fifo: single-clock FIFO; ports push/wdata in, pop in, rdata (registered head on pop), full/empty/count out
module visor_sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  sysclk,
    input  logic                  sysreset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp, rp;
    logic do_push, do_pop;
    assign full    = count == (DEPTH_LOG2+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    always_ff @(posedge sysclk)
        if (do_push) mem[wp] <= wdata;
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            rdata <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) begin
                rp    <= rp + 1'b1;
                rdata <= mem[rp];
            end
            count <= count + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
        end
    end
endmodule

// File: rtl/visor_av_writer.sv
// visor_av_writer: queues visor {addr,data} stores and issues them as Avalon writes.
// Ports: sysclk/sysreset; load_data + addr_load/ctrl_load/data_load strobes in;
// addr_reg_out, status, fifo_count out; av (master modport) drives the Avalon bus.
module visor_av_writer
    import visor_av_pkg::*;
#(
    parameter int          DEPTH_LOG2  = 3,
    parameter logic [15:0] ADDR_STRIDE = 16'd1
) (
    input  logic                sysclk,
    input  logic                sysreset,
    input  logic [15:0]         load_data,
    input  logic                addr_load,
    input  logic                ctrl_load,
    input  logic                data_load,
    output logic [15:0]         addr_reg_out,
    output logic [15:0]         status,
    output logic [DEPTH_LOG2:0] fifo_count,
    visor_av_writer_if.master   av
);
    av_state_t state, state_nx;
    av_entry_t head;
    logic [15:0] addr_reg;
    logic auto_inc, overflow, full, empty, pop;
    // The FIFO's registered head doubles as the bus address/data register,
    // so a pop loads the Avalon outputs directly.
    visor_sync_fifo #(.WIDTH($bits(av_entry_t)), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .sysclk(sysclk), .sysreset(sysreset),
        .push(data_load), .pop(pop),
        .wdata({addr_reg, load_data}), .rdata(head),
        .full(full), .empty(empty), .count(fifo_count)
    );
    always_ff @(posedge sysclk)
        state <= sysreset ? AVW_IDLE : state_nx;
    // A new head is taken whenever the bus is free or the current write completes.
    always_comb begin
        pop      = ~empty & (state == AVW_IDLE | ~av.waitrequest);
        state_nx = pop ? AVW_WRITE : (state == AVW_WRITE && av.waitrequest) ? AVW_WRITE : AVW_IDLE;
    end
    assign av.write     = state == AVW_WRITE;
    assign av.address   = head.addr;
    assign av.writedata = head.data;
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            addr_reg <= '0;
            auto_inc <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (addr_load) addr_reg <= load_data;
            else if (data_load && !full && auto_inc) addr_reg <= addr_reg + ADDR_STRIDE;
            if (ctrl_load) auto_inc <= load_data[0];
            if (data_load && full) overflow <= 1'b1;
            else if (ctrl_load && load_data[1]) overflow <= 1'b0;
        end
    end
    assign addr_reg_out = addr_reg;
    always_comb begin
        status              = '0;
        status[ST_AUTO_INC] = auto_inc;
        status[ST_BUSY]     = av.write | ~empty;
        status[ST_EMPTY]    = empty;
        status[ST_FULL]     = full;
        status[ST_OVERFLOW] = overflow;
    end
endmodule

// File: tb/tb_visor_av_writer.sv
// tb_visor_av_writer: directed and random checks of visor_av_writer against a queue-based model
module tb_visor_av_writer;
    import visor_av_pkg::*;
    logic sysclk = 1'b0;
    logic sysreset = 1'b1;
    logic [15:0] load_data = '0;
    logic addr_load = 1'b0, ctrl_load = 1'b0, data_load = 1'b0;
    logic [15:0] addr_reg_out, status;
    logic [3:0] fifo_count;
    int total = 0, bad = 0;
    visor_av_writer_if av();
    visor_av_writer #(.DEPTH_LOG2(3), .ADDR_STRIDE(16'd1)) dut (
        .sysclk(sysclk), .sysreset(sysreset), .load_data(load_data),
        .addr_load(addr_load), .ctrl_load(ctrl_load), .data_load(data_load),
        .addr_reg_out(addr_reg_out), .status(status), .fifo_count(fifo_count), .av(av)
    );
    always #5 sysclk = ~sysclk;

    // Model: pending queue, the entry on the bus, and a log of completed writes.
    av_entry_t q[$], log_q[$], bus_e, ent;
    bit bv = 0, m_ai = 0, m_ovf = 0, chk = 0, acc;
    logic [15:0] m_addr = '0;
    int n;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h @%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge sysclk) begin
        if (sysreset) begin
            q.delete();
            bv = 0; m_addr = '0; m_ai = 0; m_ovf = 0; chk = 1;
        end else begin
            n   = q.size();
            acc = data_load && n < 8;
            ent = '{addr: m_addr, data: load_data};
            if (data_load && n == 8) m_ovf = 1;
            else if (ctrl_load && load_data[1]) m_ovf = 0;
            if (addr_load) m_addr = load_data;
            else if (acc && m_ai) m_addr = m_addr + 16'd1;
            if (ctrl_load) m_ai = load_data[0];
            if (bv && !av.waitrequest) log_q.push_back(bus_e);
            if (!bv || !av.waitrequest) begin
                if (q.size() > 0) begin bus_e = q.pop_front(); bv = 1; end
                else bv = 0;
            end
            if (acc) q.push_back(ent);
        end
    end

    always @(negedge sysclk) begin
        if (chk) begin
            check("av_write", 32'(av.write), 32'(bv));
            if (bv) begin
                check("av_address", 32'(av.address), 32'(bus_e.addr));
                check("av_writedata", 32'(av.writedata), 32'(bus_e.data));
            end
            check("fifo_count", 32'(fifo_count), 32'(q.size()));
            check("addr_reg_out", 32'(addr_reg_out), 32'(m_addr));
            check("status", 32'(status), 32'({11'd0, m_ovf, q.size() == 8, q.size() == 0,
                                             bv || q.size() != 0, m_ai}));
        end
    end

    task automatic tick(input logic a, input logic c, input logic d, input logic [15:0] v);
        addr_load = a; ctrl_load = c; data_load = d; load_data = v;
        @(posedge sysclk); #2;
        addr_load = 0; ctrl_load = 0; data_load = 0; load_data = '0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) tick(0, 0, 0, 16'h0000);
    endtask

    int b;
    initial begin
        av.waitrequest = 1'b0;
        @(posedge sysclk); #2;
        sysreset = 1'b0;
        check("rst_status", 32'(status), 32'h0004);
        check("rst_write", 32'(av.write), 32'h0);
        // T1: two back-to-back writes with auto-increment
        b = log_q.size();
        tick(1, 0, 0, 16'h0100);
        tick(0, 1, 0, 16'h0001);
        tick(0, 0, 1, 16'hAAAA);
        tick(0, 0, 1, 16'hBBBB);
        idle(4);
        check("t1_n", 32'(log_q.size() - b), 32'd2);
        check("t1_w0", {log_q[b].addr, log_q[b].data}, 32'h0100AAAA);
        check("t1_w1", {log_q[b+1].addr, log_q[b+1].data}, 32'h0101BBBB);
        check("t1_status", 32'(status), 32'h0005);
        // T2: stalled write holds the bus
        av.waitrequest = 1'b1;
        tick(0, 0, 1, 16'hC001);
        idle(1);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold", {av.address, av.writedata}, 32'h0102C001);
            check("t2_wr", 32'(av.write), 32'h1);
            idle(1);
        end
        b = log_q.size();
        av.waitrequest = 1'b0;
        idle(1);
        check("t2_done", 32'(log_q.size() - b), 32'd1);
        check("t2_wr_low", 32'(av.write), 32'h0);
        // T3: overflow with a stalled bus
        av.waitrequest = 1'b1;
        tick(1, 0, 0, 16'h0300);
        for (int i = 0; i < 10; i++) tick(0, 0, 1, 16'hD000 + 16'(i));
        check("t3_count", 32'(fifo_count), 32'd8);
        check("t3_status", 32'(status), 32'h001B);
        b = log_q.size();
        av.waitrequest = 1'b0;
        idle(12);
        check("t3_n", 32'(log_q.size() - b), 32'd9);
        for (int i = 0; i < 9; i++)
            check("t3_w", {log_q[b+i].addr, log_q[b+i].data}, {16'h0300 + 16'(i), 16'hD000 + 16'(i)});
        tick(0, 1, 0, 16'h0002);
        check("t3_clr", 32'(status), 32'h0004);
        // T4: address wrap
        tick(1, 0, 0, 16'hFFFF);
        tick(0, 1, 0, 16'h0001);
        b = log_q.size();
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 16'h4000 + 16'(i));
        idle(5);
        check("t4_a0", 32'(log_q[b].addr), 32'h0000FFFF);
        check("t4_a1", 32'(log_q[b+1].addr), 32'h00000000);
        check("t4_a2", 32'(log_q[b+2].addr), 32'h00000001);
        // T5: reset mid-transfer flushes and abandons
        av.waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) tick(0, 0, 1, 16'h5000 + 16'(i));
        check("t5_pre", 32'(fifo_count), 32'd4);
        sysreset = 1'b1;
        @(posedge sysclk); #2;
        sysreset = 1'b0;
        check("t5_write", 32'(av.write), 32'h0);
        check("t5_count", 32'(fifo_count), 32'h0);
        check("t5_status", 32'(status), 32'h0004);
        av.waitrequest = 1'b0;
        b = log_q.size();
        idle(6);
        check("t5_nowr", 32'(log_q.size() - b), 32'd0);
        // T6: simultaneous addr_load and data_load uses the old address
        tick(1, 0, 0, 16'h0050);
        b = log_q.size();
        tick(1, 0, 1, 16'h0200);
        idle(3);
        check("t6_w", {log_q[b].addr, log_q[b].data}, 32'h00500200);
        check("t6_addr", 32'(addr_reg_out), 32'h0200);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            av.waitrequest = ($urandom_range(0, 1) == 1);
            sysreset = ($urandom_range(0, 99) == 0);
            tick($urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 4, 16'($urandom));
            sysreset = 1'b0;
        end
        av.waitrequest = 1'b0;
        idle(20);
        check("end_idle", 32'(av.write), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
